// File: rtl/sudoku_board_engine_if.sv
// Puzzle-load handshake between a board source (master) and the engine (slave).
// One cell moves per cycle while load_valid and load_ready are both high.
interface sudoku_board_engine_if #(
   parameter int CW = 4
) ();
   logic          load_valid;
   logic          load_ready;
   logic [CW-1:0] load_data;
   logic          load_fixed;

   modport master (
      output load_valid,
      output load_data,
      output load_fixed,
      input  load_ready
   );

   modport slave (
      input  load_valid,
      input  load_data,
      input  load_fixed,
      output load_ready
   );
endinterface

// File: rtl/sudoku_board_engine.sv
// Sudoku board engine: loads a puzzle, applies cursor moves and edits, and
// after every accepted edit scans all rows, columns and boxes one cell per cycle.
module sudoku_board_engine #(
   parameter int BOX  = 2,
   parameter int CW   = 4,
   parameter int WRAP = 0,
   localparam int N   = BOX * BOX,
   localparam int RW  = $clog2(N)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                new_game,
   sudoku_board_engine_if.slave ld,
   input  logic                mv_up,
   input  logic                mv_down,
   input  logic                mv_left,
   input  logic                mv_right,
   input  logic [CW-1:0]       num_in,
   input  logic                enter,
   input  logic                clear,
   output logic [N*N*CW-1:0]   grid,
   output logic [N*N-1:0]      fixed_mask,
   output logic [RW-1:0]       cursor_row,
   output logic [RW-1:0]       cursor_col,
   output logic                error_flag,
   output logic                range_err,
   output logic                win_flag,
   output logic                busy,
   output logic [2:0]          state,
   output logic [15:0]         move_count
);

   localparam int NN = N * N;
   localparam int IW = $clog2(NN);
   localparam int SW = N + 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_PLAY  = 3'd2,
      S_CHECK = 3'd3,
      S_WIN   = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [NN*CW-1:0]    grid_q;
   logic [NN-1:0]       fixed_q;
   logic [IW-1:0]       load_idx;
   logic [RW-1:0]       row_q, col_q;
   logic [15:0]         moves_q;
   logic                err_q, rerr_q, win_q;
   logic [1:0]          chk_kind;
   logic [RW-1:0]       chk_unit, chk_pos;
   logic [SW-1:0]       seen_q;
   logic                conflict_q, full_q;

   logic                load_fire, load_last;
   logic [CW-1:0]       load_val;
   logic [IW-1:0]       cur_idx;
   logic                cur_fixed, in_range, edit_play;
   logic                enter_ok, enter_bad, clear_ok, edit_ok;
   int                  scan_r, scan_c, scan_cell;
   logic [CW-1:0]       scan_val;
   logic [SW-1:0]       seen_base, val_bit;
   logic                conflict_d, full_d, chk_last;

   function automatic logic [RW-1:0] step(input logic [RW-1:0] p,
                                          input logic dec, input logic inc);
      step = p;
      if (inc && !dec)
         step = (p == RW'(N - 1)) ? ((WRAP != 0) ? '0 : p) : p + RW'(1);
      else if (dec && !inc)
         step = (p == '0) ? ((WRAP != 0) ? RW'(N - 1) : p) : p - RW'(1);
   endfunction

   assign ld.load_ready = (state_q == S_LOAD);
   assign load_fire     = ld.load_valid && ld.load_ready;
   assign load_last     = load_fire && (load_idx == IW'(NN - 1));
   assign load_val      = (ld.load_data > CW'(N)) ? '0 : ld.load_data;

   assign cur_idx   = IW'(int'(row_q) * N + int'(col_q));
   assign cur_fixed = fixed_q[cur_idx];
   assign in_range  = (num_in != '0) && (num_in <= CW'(N));
   assign edit_play = (state_q == S_PLAY) && !cur_fixed;
   assign enter_ok  = edit_play && enter && in_range;
   assign enter_bad = edit_play && enter && !in_range;
   assign clear_ok  = edit_play && !enter && clear;
   assign edit_ok   = enter_ok || clear_ok;

   // Scan order: kind 0 walks rows, kind 1 columns, kind 2 boxes.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      scan_r = int'(chk_unit);
      scan_c = int'(chk_pos);
      case (chk_kind)
         2'd0: begin
            scan_r = int'(chk_unit);
            scan_c = int'(chk_pos);
         end
         2'd1: begin
            scan_r = int'(chk_pos);
            scan_c = int'(chk_unit);
         end
         default: begin
            scan_r = (int'(chk_unit) / BOX) * BOX + int'(chk_pos) / BOX;
            scan_c = (int'(chk_unit) % BOX) * BOX + int'(chk_pos) % BOX;
         end
      endcase
      scan_cell = scan_r * N + scan_c;
   end

   assign scan_val   = grid_q[scan_cell*CW +: CW];
   assign seen_base  = (chk_pos == '0) ? '0 : seen_q;
   assign val_bit    = SW'(1) << scan_val;
   assign conflict_d = conflict_q || ((scan_val != '0) && ((seen_base & val_bit) != '0));
   assign full_d     = full_q && (scan_val != '0);
   assign chk_last   = (state_q == S_CHECK) && (chk_kind == 2'd2) &&
                       (chk_unit == RW'(N - 1)) && (chk_pos == RW'(N - 1));

   always_comb begin
      state_d = state_q;
      if (new_game) begin
         state_d = S_LOAD;
      end else begin
         case (state_q)
            S_IDLE:  state_d = S_IDLE;
            S_LOAD:  if (load_last) state_d = S_PLAY;
            S_PLAY:  if (edit_ok) state_d = S_CHECK;
            S_CHECK: if (chk_last) state_d = (!conflict_d && full_d) ? S_WIN : S_PLAY;
            S_WIN:   state_d = S_WIN;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= step(row_q, mv_up, mv_down);
         col_q <= step(col_q, mv_left, mv_right);
      end
   end

   // NOTE: the board is a small register file that must read back as zero after reset, so it is reset like any flop.
   always_ff @(posedge clk) begin
      if (reset || new_game) begin
         grid_q     <= '0;
         fixed_q    <= '0;
         load_idx   <= '0;
         moves_q    <= '0;
         err_q      <= 1'b0;
         rerr_q     <= 1'b0;
         win_q      <= 1'b0;
         chk_kind   <= '0;
         chk_unit   <= '0;
         chk_pos    <= '0;
         seen_q     <= '0;
         conflict_q <= 1'b0;
         full_q     <= 1'b1;
      end else begin
         if (load_fire) begin
            grid_q[load_idx*CW +: CW] <= load_val;
            fixed_q[load_idx]         <= ld.load_fixed && (load_val != '0);
            load_idx                  <= load_idx + IW'(1);
         end
         if (enter_ok) begin
            grid_q[cur_idx*CW +: CW] <= num_in;
            rerr_q                   <= 1'b0;
         end
         if (clear_ok) grid_q[cur_idx*CW +: CW] <= '0;
         if (enter_bad) rerr_q <= 1'b1;
         if (edit_ok) begin
            if (moves_q != 16'hFFFF) moves_q <= moves_q + 16'd1;
            chk_kind   <= '0;
            chk_unit   <= '0;
            chk_pos    <= '0;
            seen_q     <= '0;
            conflict_q <= 1'b0;
            full_q     <= 1'b1;
         end
         if (state_q == S_CHECK) begin
            seen_q     <= seen_base | val_bit;
            conflict_q <= conflict_d;
            full_q     <= full_d;
            if (chk_pos == RW'(N - 1)) begin
               chk_pos <= '0;
               if (chk_unit == RW'(N - 1)) begin
                  chk_unit <= '0;
                  chk_kind <= chk_kind + 2'd1;
               end else begin
                  chk_unit <= chk_unit + RW'(1);
               end
            end else begin
               chk_pos <= chk_pos + RW'(1);
            end
            if (chk_last) begin
               err_q <= conflict_d;
               win_q <= !conflict_d && full_d;
            end
         end
      end
   end

   assign grid       = grid_q;
   assign fixed_mask = fixed_q;
   assign cursor_row = row_q;
   assign cursor_col = col_q;
   assign error_flag = err_q;
   assign range_err  = rerr_q;
   assign win_flag   = win_q;
   assign busy       = (state_q == S_LOAD) || (state_q == S_CHECK);
   assign state      = state_q;
   assign move_count = moves_q;

endmodule
